// File: rtl/id_stage_regfile.sv
// Pipelined decode stage: 2R/1W register file, immediate extension, destination select,
// load-use hazard detection and the ID/EX register. Define ID_WB_BYPASS_EN for write-through reads.
module id_stage_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    localparam int AW     = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] opcplus4,
    input  logic              Jal,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              RegDst,
    input  logic              MemRead,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic              wb_jal,
    input  logic              wb_memtoreg,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [DATA_W-1:0] wb_read_data,
    input  logic [DATA_W-1:0] wb_pc4,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_sign_extend,
    output logic [AW-1:0]     ex_rs,
    output logic [AW-1:0]     ex_rt,
    output logic [AW-1:0]     ex_wr_addr,
    output logic              ex_RegWrite,
    output logic              ex_MemtoReg,
    output logic              ex_MemRead,
    output logic              ex_Jal,
    output logic [DATA_W-1:0] ex_pc4
);

    logic [DATA_W-1:0] regs [REG_NUM];
    logic [AW-1:0]     rs, rt, rd, dst;
    logic [DATA_W-1:0] wb_data, rd1, rd2, imm_ext;
    logic [5:0]        opcode;
    logic              zext;

    // 5-bit instruction fields are truncated or zero-padded to the register-address width.
    function automatic logic [AW-1:0] fld(input logic [4:0] f);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW && i < 5; i++) r[i] = f[i];
        return r;
    endfunction

    assign rs     = fld(instruction[25:21]);
    assign rt     = fld(instruction[20:16]);
    assign rd     = fld(instruction[15:11]);
    assign opcode = instruction[31:26];

    assign wb_data = wb_jal ? wb_pc4 : (wb_memtoreg ? wb_read_data : wb_alu_result);

    always_comb begin
        rd1 = regs[rs];
        rd2 = regs[rt];
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_addr == rs) rd1 = wb_data;
        if (wb_en && wb_addr == rt) rd2 = wb_data;
`endif
        if (rs == '0) rd1 = '0;
        if (rt == '0) rd2 = '0;
    end

    // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
    assign zext    = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
    assign imm_ext = zext ? {{(DATA_W-16){1'b0}}, instruction[15:0]}
                          : {{(DATA_W-16){instruction[15]}}, instruction[15:0]};

    assign dst = Jal ? AW'(REG_NUM - 1) : (RegDst ? rd : rt);

    assign load_use_stall = id_valid && ex_valid && ex_MemRead && (ex_wr_addr != '0) &&
                            ((ex_wr_addr == rs) || (ex_wr_addr == rt));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Handshake: ex_valid qualifies the ID/EX entry; stall is EX backpressure and freezes the
    // whole entry; flush and load-use insert a bubble (valid/RegWrite/MemRead cleared).
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid       <= 1'b0;
            ex_read_data_1 <= '0;
            ex_read_data_2 <= '0;
            ex_sign_extend <= '0;
            ex_rs          <= '0;
            ex_rt          <= '0;
            ex_wr_addr     <= '0;
            ex_RegWrite    <= 1'b0;
            ex_MemtoReg    <= 1'b0;
            ex_MemRead     <= 1'b0;
            ex_Jal         <= 1'b0;
            ex_pc4         <= '0;
        end else if (!stall) begin
            ex_read_data_1 <= rd1;
            ex_read_data_2 <= rd2;
            ex_sign_extend <= imm_ext;
            ex_rs          <= rs;
            ex_rt          <= rt;
            ex_wr_addr     <= dst;
            ex_MemtoReg    <= MemtoReg;
            ex_Jal         <= Jal;
            ex_pc4         <= opcplus4;
            if (flush || load_use_stall) begin
                ex_valid    <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemRead  <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_RegWrite <= RegWrite;
                ex_MemRead  <= MemRead;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_regfile.sv
// Directed bench for id_stage_regfile: expected ID/EX contents are queued per edge and a
// monitor compares them after each rising edge.
module tb_id_stage_regfile;

    localparam int EW = 1 + 3*32 + 3*5 + 4 + 32;

    logic        clk = 1'b0;
    logic        rst, id_valid, Jal, RegWrite, MemtoReg, RegDst, MemRead, stall, flush;
    logic [31:0] instruction, opcplus4;
    logic        wb_en, wb_jal, wb_memtoreg;
    logic [4:0]  wb_addr;
    logic [31:0] wb_alu_result, wb_read_data, wb_pc4;
    logic        load_use_stall, ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_Jal;
    logic [31:0] ex_read_data_1, ex_read_data_2, ex_sign_extend, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_wr_addr;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] msk_q[$];
    string         nm_q[$];
    logic [EW-1:0] act, full_m, bub_m, last_e, e;

    always #5 clk = ~clk;

    id_stage_regfile dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instruction(instruction),
        .opcplus4(opcplus4), .Jal(Jal), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .MemRead(MemRead), .stall(stall), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_jal(wb_jal), .wb_memtoreg(wb_memtoreg),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data), .wb_pc4(wb_pc4),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2),
        .ex_sign_extend(ex_sign_extend), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_wr_addr(ex_wr_addr), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_MemRead(ex_MemRead), .ex_Jal(ex_Jal), .ex_pc4(ex_pc4)
    );

    assign act = {ex_valid, ex_read_data_1, ex_read_data_2, ex_sign_extend, ex_rs, ex_rt,
                  ex_wr_addr, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_Jal, ex_pc4};

    function automatic logic [EW-1:0] mk(input logic v, input logic [31:0] d1, d2, se,
                                         input logic [4:0] a_rs, a_rt, a_wr,
                                         input logic rw, mtr, mr, jl, input logic [31:0] pc);
        return {v, d1, d2, se, a_rs, a_rt, a_wr, rw, mtr, mr, jl, pc};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // Immediate field of r_ins with rd < 16 is positive: {rd, 00000, 100000}.
    function automatic logic [31:0] r_se(input logic [4:0] d);
        return {16'h0, d, 11'h020};
    endfunction

    task automatic set_id(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic jl, rw, mtr, rdst, mr);
        id_valid = v; instruction = ins; opcplus4 = pc;
        Jal = jl; RegWrite = rw; MemtoReg = mtr; RegDst = rdst; MemRead = mr;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] a, input logic jl, mtr,
                          input logic [31:0] alu, rdat, pc4);
        wb_en = en; wb_addr = a; wb_jal = jl; wb_memtoreg = mtr;
        wb_alu_result = alu; wb_read_data = rdat; wb_pc4 = pc4;
    endtask

    task automatic check_lus(input string nm, input logic req);
        #1;
        checks++;
        if (load_use_stall !== req) begin
            errors++;
            $display("FAIL %s: load_use_stall actual %b required %b", nm, load_use_stall, req);
        end
    endtask

    task automatic step(input string nm, input logic [EW-1:0] ex, input logic [EW-1:0] m);
        exp_q.push_back(ex);
        msk_q.push_back(m);
        nm_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [EW-1:0] pe, pm;
        string pn;
        #1;
        if (exp_q.size() > 0) begin
            pe = exp_q.pop_front();
            pm = msk_q.pop_front();
            pn = nm_q.pop_front();
            checks++;
            if ((act & pm) !== (pe & pm)) begin
                errors++;
                $display("FAIL %s: idex actual %h required %h mask %h", pn, act, pe, pm);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        full_m = '1;
        bub_m  = mk(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        set_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd1, 5'd2, 5'd3), 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("reset", '0, full_m);
        check_lus("reset_lus", 1'b0);
        rst = 1'b1;

        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) begin
            set_id(1'b1, r_ins(5'(2*i), 5'(2*i+1), 5'd3), 32'h100 + 32'(4*i),
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            step("read_zero", mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'(2*i), 5'(2*i+1), 5'd3,
                                 1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + 32'(4*i)), full_m);
        end

        set_wb(1'b1, 5'd5, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd1, 5'd2, 5'd3), 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("wr_r5", mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'd1, 5'd2, 5'd3,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h200), full_m);

        set_wb(1'b1, 5'd0, 1'b0, 1'b0, 32'hFFFF, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd5, 5'd0, 5'd4), 32'h204, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rd_r5", mk(1'b1, 32'h1234, 32'h0, r_se(5'd4), 5'd5, 5'd0, 5'd4,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h204), full_m);

        set_wb(1'b1, 5'd6, 1'b0, 1'b1, 32'h5555, 32'hDEADBEEF, 32'h0);
        set_id(1'b1, r_ins(5'd0, 5'd5, 5'd6), 32'h208, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rd_r0", mk(1'b1, 32'h0, 32'h1234, r_se(5'd6), 5'd0, 5'd5, 5'd6,
                         1'b1, 1'b0, 1'b0, 1'b0, 32'h208), full_m);

        set_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_id(1'b1, i_ins(6'h0D, 5'd6, 5'd10, 16'h8001), 32'h20C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ori", mk(1'b1, 32'hDEADBEEF, 32'h0, 32'h00008001, 5'd6, 5'd10, 5'd10,
                       1'b1, 1'b0, 1'b0, 1'b0, 32'h20C), full_m);

        set_id(1'b1, i_ins(6'h08, 5'd5, 5'd11, 16'h8001), 32'h210, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("addi", mk(1'b1, 32'h1234, 32'h0, 32'hFFFF8001, 5'd5, 5'd11, 5'd11,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'h210), full_m);

        set_id(1'b1, i_ins(6'h0C, 5'd0, 5'd12, 16'hFFFF), 32'h214, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("andi", mk(1'b1, 32'h0, 32'h0, 32'h0000FFFF, 5'd0, 5'd12, 5'd12,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'h214), full_m);

        set_id(1'b1, i_ins(6'h0E, 5'd6, 5'd13, 16'h8000), 32'h218, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("xori", mk(1'b1, 32'hDEADBEEF, 32'h0, 32'h00008000, 5'd6, 5'd13, 5'd13,
                        1'b1, 1'b0, 1'b0, 1'b0, 32'h218), full_m);

        set_id(1'b1, 32'h0C000000, 32'h00400008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("jal", mk(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31,
                       1'b1, 1'b0, 1'b0, 1'b1, 32'h00400008), full_m);

        set_wb(1'b1, 5'd31, 1'b1, 1'b1, 32'h77, 32'h88, 32'h00400008);
        set_id(1'b1, r_ins(5'd1, 5'd2, 5'd3), 32'h220, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("wb_jal", mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'd1, 5'd2, 5'd3,
                          1'b1, 1'b0, 1'b0, 1'b0, 32'h220), full_m);

        set_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd31, 5'd6, 5'd1), 32'h224, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rd_r31", mk(1'b1, 32'h00400008, 32'hDEADBEEF, r_se(5'd1), 5'd31, 5'd6, 5'd1,
                          1'b1, 1'b0, 1'b0, 1'b0, 32'h224), full_m);

        // Load-use on rs, then on rt: one bubble, then the consumer loads.
        for (int k = 0; k < 2; k++) begin
            logic [4:0] cs, ct;
            cs = (k == 0) ? 5'd8 : 5'd2;
            ct = (k == 0) ? 5'd2 : 5'd8;
            set_id(1'b1, i_ins(6'h23, 5'd5, 5'd8, 16'h0004), 32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            check_lus("lw_lus", 1'b0);
            step("lw", mk(1'b1, 32'h1234, 32'h0, 32'h4, 5'd5, 5'd8, 5'd8,
                          1'b1, 1'b1, 1'b1, 1'b0, 32'h300), full_m);
            set_id(1'b1, r_ins(cs, ct, 5'd9), 32'h304, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            check_lus("lu_detect", 1'b1);
            step("lu_bubble", '0, bub_m);
            check_lus("lu_clear", 1'b0);
            step("lu_load", mk(1'b1, 32'h0, 32'h0, r_se(5'd9), cs, ct, 5'd9,
                               1'b1, 1'b0, 1'b0, 1'b0, 32'h304), full_m);
        end

        // A load to r0 never creates a hazard.
        set_id(1'b1, i_ins(6'h23, 5'd5, 5'd0, 16'h0000), 32'h310, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("lw_r0", mk(1'b1, 32'h1234, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0,
                         1'b1, 1'b1, 1'b1, 1'b0, 32'h310), full_m);
        set_id(1'b1, r_ins(5'd0, 5'd0, 5'd3), 32'h314, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_lus("lu_r0", 1'b0);
        last_e = mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'd0, 5'd0, 5'd3,
                    1'b1, 1'b0, 1'b0, 1'b0, 32'h314);
        step("after_lw_r0", last_e, full_m);

        stall = 1'b1; flush = 1'b1;
        set_id(1'b1, r_ins(5'd1, 5'd2, 5'd4), 32'h318, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("stall_flush_hold", last_e, full_m);
        stall = 1'b0;
        step("flush_bubble", '0, bub_m);
        flush = 1'b0;

        set_id(1'b1, r_ins(5'd5, 5'd6, 5'd3), 32'h31C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("pre_reset", mk(1'b1, 32'h1234, 32'hDEADBEEF, 32'h1820, 5'd5, 5'd6, 5'd3,
                             1'b1, 1'b0, 1'b0, 1'b0, 32'h31C), full_m);
        stall = 1'b1; rst = 1'b0;
        step("reset_in_stall", '0, full_m);
        stall = 1'b0; rst = 1'b1;
        set_id(1'b1, r_ins(5'd5, 5'd6, 5'd3), 32'h320, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("regs_cleared", mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'd5, 5'd6, 5'd3,
                                1'b1, 1'b0, 1'b0, 1'b0, 32'h320), full_m);

        set_wb(1'b1, 5'd7, 1'b0, 1'b0, 32'h1111, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd1, 5'd2, 5'd3), 32'h324, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("wr_r7_old", mk(1'b1, 32'h0, 32'h0, 32'h1820, 5'd1, 5'd2, 5'd3,
                             1'b1, 1'b0, 1'b0, 1'b0, 32'h324), full_m);
        set_wb(1'b1, 5'd7, 1'b0, 1'b0, 32'hCAFE, 32'h0, 32'h0);
        set_id(1'b1, r_ins(5'd7, 5'd0, 5'd3), 32'h328, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef ID_WB_BYPASS_EN
        e = mk(1'b1, 32'hCAFE, 32'h0, 32'h1820, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h328);
`else
        e = mk(1'b1, 32'h1111, 32'h0, 32'h1820, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h328);
`endif
        step("bypass", e, full_m);
        set_wb(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        step("rd_r7_new", mk(1'b1, 32'hCAFE, 32'h0, 32'h1820, 5'd7, 5'd0, 5'd3,
                             1'b1, 1'b0, 1'b0, 1'b0, 32'h328), full_m);

        @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: queue depth actual %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_regfile.md
# id_stage_regfile

Pipelined instruction-decode stage for the five-stage CooperCPU core: parametrised register file (2 read, 1 write), writeback-source mux, immediate extension, destination select, load-use hazard detection and the ID/EX pipeline register with stall/flush control. Sits between the iFetch IF/ID register and the Executer; it is the pipelined successor of the single-cycle decoder.

## Interface
- DATA_W, 32, register/data width (≥16)
- REG_NUM, 32, register count (power of two); AW = $clog2(REG_NUM) is the register-address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- id_valid  in  1  instruction in ID is valid
- instruction  in  32  MIPS instruction from IF/ID
- opcplus4  in  DATA_W  PC+4 of ID instruction
- Jal, RegWrite, MemtoReg, RegDst, MemRead  in  1 each  controller outputs for ID instruction
- stall  in  1  EX backpressure; ID/EX register holds
- flush  in  1  branch/jump redirect; ID/EX loads bubble
- wb_en  in  1  writeback enable
- wb_addr  in  AW  writeback register
- wb_jal, wb_memtoreg  in  1 each  writeback source select
- wb_alu_result, wb_read_data, wb_pc4  in  DATA_W  writeback sources
- load_use_stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  ID/EX entry valid
- ex_read_data_1, ex_read_data_2, ex_sign_extend  out  DATA_W
- ex_rs, ex_rt, ex_wr_addr  out  AW
- ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_Jal  out  1 each
- ex_pc4  out  DATA_W

## Operation
- rs = instruction[25:21], rt = [20:16], rd = [15:11], truncated/zero-padded to AW.
- Writeback data: wb_jal ? wb_pc4 : wb_memtoreg ? wb_read_data : wb_alu_result.
- Write: at posedge when wb_en && wb_addr != 0. Register 0 always reads 0; writes to it are discarded.
- Immediate: opcode 0x0C/0x0D/0x0E (andi/ori/xori) zero-extend [15:0] to DATA_W; all other opcodes sign-extend.
- Destination: Jal → REG_NUM-1 (31); else RegDst → rd; else rt.
- load_use_stall = id_valid && ex_valid && ex_MemRead && ex_wr_addr != 0 && (ex_wr_addr == rs || ex_wr_addr == rt).
- ID/EX update priority per edge: reset (all cleared) > stall (hold all) > flush (ex_valid=0, ex_RegWrite=0, ex_MemRead=0) > load_use_stall (same bubble) > load (ex_valid=id_valid, all ex_* from ID).
- Bubbles: data fields don't-care, but ex_RegWrite/ex_MemRead forced 0.
- flush during stall is not latched; the upstream must hold flush until stall drops.

## Timing
- Register read combinational; ID/EX outputs valid 1 cycle after ID presentation.
- Write visible to combinational read the cycle after the write edge (same cycle if bypass enabled, see Configuration).
- Reset: while rst=0 at an edge, all REG_NUM registers and all ex_* outputs become 0; load_use_stall then 0 since ex_valid=0. Reset mid-stall discards the held entry.
- Simultaneous wb write and ID/EX load: both occur at the same edge, independent.

## Configuration
- ID_WB_BYPASS_EN defined: read port returns writeback data when wb_en && wb_addr == read address != 0 in the same cycle (write-through).
- Undefined: read returns stored (old) value; hazard spacing is the compiler's/forwarding unit's responsibility.

## Test plan
- Reset: rst=0 one edge, then read all 32 regs via addi-less ID reads → all 0; ex_valid=0, all ex_* 0.
- Write/read: wb_en=1, wb_addr=5, wb_alu_result=0x1234 at edge; next cycle rs=5 → ex_read_data_1=0x1234 after following edge; write to r0 with 0xFFFF → reads 0.
- Immediate: ori imm 0x8001 → ex_sign_extend=0x00008001; addi imm 0x8001 → 0xFFFF8001; jal → ex_wr_addr=31, wb_jal writes opcplus4 value 0x00400008.
- Load-use: lw to r8 in EX (ex_MemRead=1), add r9,r8,r2 in ID → load_use_stall=1, next ex_valid=0; following cycle stall clears and add loads.
- stall/flush: stall=1 with flush=1 → ID/EX unchanged; stall=0 flush=1 → ex_valid=0, ex_RegWrite=0.
- Bypass: same-cycle wb to r7=0xCAFE with rs=7 → ex_read_data_1=0xCAFE with ID_WB_BYPASS_EN, old value without.
